// File: rtl/m_ext_sequencer_if.sv
// m_ext_sequencer_if
//   Bundles the execute-stage request/response signals and the external
//   multiplier handshake of the RV32M sequencer.
//
//   Request side   : start, funct3, rs1_data, rs2_data
//   Response side  : busy, done, result
//   Multiplier side: mul_enable, mul_a, mul_b (to the multiplier controller),
//                    mul_resp, product (back from the Wallace tree)
//
//   slave  modport : the sequencer itself
//   master modport : the pipeline / multiplier environment around it
interface m_ext_sequencer_if;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        mul_resp;
  logic [63:0] product;
  logic        mul_enable;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  modport slave (
    input  start, funct3, rs1_data, rs2_data, mul_resp, product,
    output mul_enable, mul_a, mul_b, busy, done, result
  );

  modport master (
    output start, funct3, rs1_data, rs2_data, mul_resp, product,
    input  mul_enable, mul_a, mul_b, busy, done, result
  );
endinterface

// File: rtl/m_ext_sequencer.sv
// m_ext_sequencer
//   Multi-cycle sequencer for the RV32M extension. Multiplies are handed to
//   an external unsigned multiplier as operand magnitudes and the 64-bit
//   product is sign-corrected on return. Divides run a 32-step restoring
//   divider on magnitudes, followed by sign correction. Divide-by-zero and
//   signed overflow skip the iteration and go straight to sign correction
//   with the architecturally defined results preloaded.
//
// Ports
//   clk  : clock, all state on the rising edge
//   rst  : synchronous, active-high reset
//   bus  : m_ext_sequencer_if.slave
//          start/funct3/rs1_data/rs2_data  request from execute stage
//          busy/done/result                stall, completion pulse, value
//          mul_enable/mul_a/mul_b          request to multiplier controller
//          mul_resp/product                multiplier completion and result
module m_ext_sequencer (
  input logic                  clk,
  input logic                  rst,
  m_ext_sequencer_if.slave     bus
);

  localparam int DATA_W = 32;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_MUL_REQ  = 3'd1;
  localparam logic [2:0] S_MUL_WAIT = 3'd2;
  localparam logic [2:0] S_DIV_ITER = 3'd3;
  localparam logic [2:0] S_FIXUP    = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  localparam logic [2:0] OP_MUL = 3'b000;

  function automatic logic [DATA_W-1:0] neg32(input logic [DATA_W-1:0] x);
    neg32 = ~x + {{(DATA_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*DATA_W-1:0] neg64(input logic [2*DATA_W-1:0] x);
    neg64 = ~x + {{(2*DATA_W-1){1'b0}}, 1'b1};
  endfunction

  // Two's-complement magnitude; 0x80000000 maps onto itself, which read as
  // unsigned is exactly the magnitude of INT_MIN.
  function automatic logic [DATA_W-1:0] mag32(input logic [DATA_W-1:0] x,
                                              input logic              neg);
    mag32 = neg ? neg32(x) : x;
  endfunction

  logic [2:0]        state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              qneg_q, qneg_d;     // quotient / product must be negated
  logic              rneg_q, rneg_d;     // remainder must be negated
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              fix_ph_q, fix_ph_d;
  logic [DATA_W-1:0] result_q, result_d;

  // Operand decode for the incoming request
  logic              sgn_a, sgn_b;
  logic              neg_a, neg_b;
  logic [DATA_W-1:0] mag_a, mag_b;
  logic              div_zero, div_ovf;

  always_comb begin
    if (bus.funct3[2]) begin
      // DIV/REM signed, DIVU/REMU unsigned
      sgn_a = ~bus.funct3[0];
      sgn_b = ~bus.funct3[0];
    end else begin
      // MUL/MULH both signed, MULHSU only A signed, MULHU neither
      sgn_a = (bus.funct3[1:0] != 2'b11);
      sgn_b = ~bus.funct3[1];
    end
  end

  assign neg_a    = sgn_a & bus.rs1_data[DATA_W-1];
  assign neg_b    = sgn_b & bus.rs2_data[DATA_W-1];
  assign mag_a    = mag32(bus.rs1_data, neg_a);
  assign mag_b    = mag32(bus.rs2_data, neg_b);
  assign div_zero = (bus.rs2_data == '0);
  assign div_ovf  = ~bus.funct3[0] &
                    (bus.rs1_data == 32'h8000_0000) &
                    (bus.rs2_data == 32'hFFFF_FFFF);

  // Restoring-divide step: shift the next dividend bit into the partial
  // remainder and subtract the divisor when it fits. The subtraction only
  // matters when rem_sh >= divisor, in which case the difference fits in
  // 32 bits, so a 32-bit modular subtract is sufficient.
  logic [DATA_W:0]   rem_sh;
  logic              rem_ge;
  logic [DATA_W-1:0] rem_sub;

  assign rem_sh  = {rem_q, quo_q[DATA_W-1]};
  assign rem_ge  = (rem_sh >= {1'b0, b_q});
  assign rem_sub = rem_sh[DATA_W-1:0] - b_q;

  // Sign-corrected product, only used while the response is present
  logic [2*DATA_W-1:0] prod_fix;

  assign prod_fix = qneg_q ? neg64(bus.product) : bus.product;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    fix_ph_d = fix_ph_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        fix_ph_d = 1'b0;
        if (bus.start) begin
          op_d   = bus.funct3;
          a_d    = mag_a;
          b_d    = mag_b;
          qneg_d = neg_a ^ neg_b;
          rneg_d = neg_a;
          if (!bus.funct3[2]) begin
            state_d = S_MUL_REQ;
          end else if (div_zero) begin
            // Quotient all ones, remainder is the untouched dividend
            quo_d   = 32'hFFFF_FFFF;
            rem_d   = bus.rs1_data;
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
            state_d = S_FIXUP;
          end else if (div_ovf) begin
            quo_d   = 32'h8000_0000;
            rem_d   = '0;
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
            state_d = S_FIXUP;
          end else begin
            quo_d   = mag_a;
            rem_d   = '0;
            cnt_d   = '0;
            state_d = S_DIV_ITER;
          end
        end
      end

      S_MUL_REQ: begin
        state_d = S_MUL_WAIT;
      end

      S_MUL_WAIT: begin
        if (bus.mul_resp) begin
          result_d = (op_q == OP_MUL) ? prod_fix[DATA_W-1:0]
                                      : prod_fix[2*DATA_W-1:DATA_W];
          state_d  = S_DONE;
        end
      end

      S_DIV_ITER: begin
        if (rem_ge) begin
          rem_d = rem_sub;
          quo_d = {quo_q[DATA_W-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[DATA_W-1:0];
          quo_d = {quo_q[DATA_W-2:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_FIXUP;
        end
      end

      S_FIXUP: begin
        // Two phases: sign correction of quotient and remainder, then the
        // quotient/remainder select into the result register.
        if (!fix_ph_q) begin
          quo_d    = qneg_q ? neg32(quo_q) : quo_q;
          rem_d    = rneg_q ? neg32(rem_q) : rem_q;
          fix_ph_d = 1'b1;
        end else begin
          result_d = op_q[1] ? rem_q : quo_q;
          fix_ph_d = 1'b0;
          state_d  = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      quo_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      fix_ph_q <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      fix_ph_q <= fix_ph_d;
      result_q <= result_d;
    end
  end

  assign bus.mul_enable = (state_q == S_MUL_REQ);
  assign bus.mul_a      = a_q;
  assign bus.mul_b      = b_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.result     = result_q;

endmodule

// File: tb/tb_m_ext_sequencer.sv
// tb_m_ext_sequencer
//   Directed bench for m_ext_sequencer. A small stand-in multiplier answers
//   each mul_enable two cycles later with the unsigned product of mul_a and
//   mul_b. Expected results are hand-computed RV32M values.
module tb_m_ext_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  m_ext_sequencer_if bus ();

  m_ext_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Stand-in multiplier controller: response two cycles after the request
  logic        en_d1      = 1'b0;
  logic        model_resp = 1'b0;
  logic        inj_resp;
  logic [63:0] model_prod = '0;

  always @(posedge clk) begin
    en_d1      <= bus.mul_enable;
    model_resp <= en_d1;
    model_prod <= {32'b0, bus.mul_a} * {32'b0, bus.mul_b};
  end

  assign bus.mul_resp = model_resp | inj_resp;
  assign bus.product  = model_prod;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues one request and follows it to completion. lat counts cycles from
  // the start cycle to the done cycle (60 means no done was seen).
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input bit hold, output int lat, output int en_cnt,
                        output logic [31:0] ma, output logic [31:0] mb,
                        output int busy_low, output int extra_done,
                        output logic [31:0] res, output logic [31:0] res_after);
    bus.start    = 1'b1;
    bus.funct3   = f3;
    bus.rs1_data = a;
    bus.rs2_data = b;
    lat = 0; en_cnt = 0; busy_low = 0; extra_done = 0; ma = '0; mb = '0;
    @(posedge clk); #1;
    lat = 1;
    if (!hold) bus.start = 1'b0;
    while (bus.done !== 1'b1 && lat < 60) begin
      if (bus.busy !== 1'b1) busy_low++;
      if (bus.mul_enable === 1'b1) begin
        en_cnt++;
        ma = bus.mul_a;
        mb = bus.mul_b;
      end
      @(posedge clk); #1;
      lat++;
    end
    res = bus.result;
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) extra_done++;
    end
    res_after = bus.result;
  endtask

  int          lat, en_cnt, busy_low, extra_done, done_cnt;
  logic [31:0] ma, mb, res, res_after;

  initial begin
    rst          = 1'b1;
    inj_resp     = 1'b0;
    bus.start    = 1'b0;
    bus.funct3   = 3'b000;
    bus.rs1_data = '0;
    bus.rs2_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",   bus.busy,       1'b0);
    chk("rst_done",   bus.done,       1'b0);
    chk("rst_mul_en", bus.mul_enable, 1'b0);
    chk("rst_result", bus.result,     32'h0);
    chk("rst_mul_a",  bus.mul_a,      32'h0);
    chk("rst_mul_b",  bus.mul_b,      32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // MUL -1 * 7
    run_op(3'b000, 32'hFFFF_FFFF, 32'd7, 1'b0, lat, en_cnt, ma, mb, busy_low, extra_done, res, res_after);
    chk("mul_lat",    lat,        4);
    chk("mul_en_cnt", en_cnt,     1);
    chk("mul_a_mag",  ma,         32'h1);
    chk("mul_b_mag",  mb,         32'h7);
    chk("mul_res",    res,        32'hFFFF_FFF9);
    chk("mul_busy",   busy_low,   0);
    chk("mul_extra",  extra_done, 0);
    chk("mul_hold",   res_after,  32'hFFFF_FFF9);

    // MULHU / MULH / MULHSU with both operands all ones
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, en_cnt, ma, mb, busy_low, extra_done, res, res_after);
    chk("mulhu_res",  res, 32'hFFFF_FFFE);
    chk("mulhu_lat",  lat, 4);
    chk("mulhu_a",    ma,  32'hFFFF_FFFF);
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, en_cnt, ma, mb, busy_low, extra_done, res, res_after);
    chk("mulh_res",   res, 32'h0000_0000);
    chk("mulh_b",     mb,  32'h1);
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, en_cnt, ma, mb, busy_low, extra_done, res, res_after);
    chk("mulhsu_res", res, 32'hFFFF_FFFF);
    chk("mulhsu_a",   ma,  32'h1);
    chk("mulhsu_b",   mb,  32'hFFFF_FFFF);

    // Signed divide -7 / 2 and remainder
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 1'b0, lat, en_cnt, ma, mb, busy_low, extra_done, res, res_after);
    chk("div_lat",    lat,    35);
    chk("div_res",    res,    32'hFFFF_FFFD);
    chk("div_no_mul", en_cnt, 0);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 1'b0, lat, en_cnt, ma, mb, busy_low, extra_done, res, res_after);
    chk("rem_lat",    lat, 35);
    chk("rem_res",    res, 32'hFFFF_FFFF);

    // DIVU 100 / 7 with start held high throughout
    run_op(3'b101, 32'd100, 32'd7, 1'b1, lat, en_cnt, ma, mb, busy_low, extra_done, res, res_after);
    chk("divu_hold_lat",   lat,        35);
    chk("divu_hold_res",   res,        32'd14);
    chk("divu_hold_busy",  busy_low,   0);
    chk("divu_hold_extra", extra_done, 0);
    chk("divu_hold_keep",  res_after,  32'd14);

    // Special cases: divide by zero and signed overflow
    run_op(3'b101, 32'h0000_1234, 32'h0, 1'b0, lat, en_cnt, ma, mb, busy_low, extra_done, res, res_after);
    chk("divu0_lat",  lat, 3);
    chk("divu0_res",  res, 32'hFFFF_FFFF);
    run_op(3'b111, 32'h0000_1234, 32'h0, 1'b0, lat, en_cnt, ma, mb, busy_low, extra_done, res, res_after);
    chk("remu0_lat",  lat, 3);
    chk("remu0_res",  res, 32'h0000_1234);
    run_op(3'b110, 32'hFFFF_FFF9, 32'h0, 1'b0, lat, en_cnt, ma, mb, busy_low, extra_done, res, res_after);
    chk("rem0_res",   res, 32'hFFFF_FFF9);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, en_cnt, ma, mb, busy_low, extra_done, res, res_after);
    chk("divovf_lat", lat, 3);
    chk("divovf_res", res, 32'h8000_0000);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, en_cnt, ma, mb, busy_low, extra_done, res, res_after);
    chk("removf_lat", lat, 3);
    chk("removf_res", res, 32'h0);

    run_op(3'b111, 32'd100, 32'd7, 1'b0, lat, en_cnt, ma, mb, busy_low, extra_done, res, res_after);
    chk("remu_res",   res, 32'd2);

    // Reset at the tenth divide iteration
    bus.start    = 1'b1;
    bus.funct3   = 3'b100;
    bus.rs1_data = 32'd1000;
    bus.rs2_data = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    chk("mid_busy", bus.busy, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy",   bus.busy,   1'b0);
    chk("midrst_done",   bus.done,   1'b0);
    chk("midrst_result", bus.result, 32'h0);
    chk("midrst_mul_a",  bus.mul_a,  32'h0);

    // Stray multiplier response while idle
    inj_resp = 1'b1;
    @(posedge clk); #1;
    inj_resp = 1'b0;
    chk("stray_busy", bus.busy, 1'b0);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) done_cnt++;
      @(posedge clk); #1;
    end
    chk("midrst_no_done", done_cnt, 0);

    run_op(3'b000, 32'd6, 32'd7, 1'b0, lat, en_cnt, ma, mb, busy_low, extra_done, res, res_after);
    chk("post_rst_lat", lat, 4);
    chk("post_rst_res", res, 32'd42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/m_ext_sequencer.md
M_EXT_SEQUENCER -- requirements
Module: m_ext_sequencer

Interface
REQ-001 SHALL have ports: clk  input  1  clock, all state on rising edge.
REQ-002 SHALL have ports: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports: start  input  1  request strobe from execute stage; sampled only in IDLE.
REQ-004 SHALL have ports: funct3  input  3  RV32M op (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU).
REQ-005 SHALL have ports: rs1_data  input  32  operand A; rs2_data  input  32  operand B.
REQ-006 SHALL have ports: mul_resp  input  1  completion pulse from multiplier controller.
REQ-007 SHALL have ports: product  input  64  unsigned product of mul_a*mul_b from Wallace tree; valid while mul_resp=1.
REQ-008 SHALL have ports: mul_enable  output  1  one-cycle request to multiplier controller.
REQ-009 SHALL have ports: mul_a, mul_b  output  32 each  operand magnitudes to multiplier, held stable from request until mul_resp.
REQ-010 SHALL have ports: busy  output  1  stall to pipeline, =1 whenever state != IDLE.
REQ-011 SHALL have ports: done  output  1  one-cycle result-valid pulse; result  output  32  final value.

Function
REQ-012 SHALL implement states IDLE, MUL_REQ, MUL_WAIT, DIV_ITER, FIXUP, DONE.
REQ-013 IDLE: start=1 SHALL latch funct3, rs1_data, rs2_data and sign flags; MUL ops -> MUL_REQ, DIV/REM ops -> DIV_ITER (or FIXUP on special case); start=0 -> stay.
REQ-014 Signedness: MUL/MULH both signed; MULHSU A signed, B unsigned; MULHU/DIVU/REMU unsigned; DIV/REM signed.
REQ-015 mul_a/mul_b SHALL be two's-complement magnitudes of signed operands (0x80000000 maps to 0x80000000 unsigned); unsigned operands pass unchanged.
REQ-016 MUL_REQ: mul_enable=1 exactly one cycle, -> MUL_WAIT unconditionally.
REQ-017 MUL_WAIT: on mul_resp=1 capture product, negate full 64 bits if signs differ (signed operands only), -> DONE; otherwise stay, mul_enable=0.
REQ-018 Result select: MUL low 32 bits; MULH/MULHSU/MULHU high 32 bits of sign-corrected product.
REQ-019 DIV_ITER: restoring divide on magnitudes, one quotient bit per cycle, 5-bit counter 0..31, -> FIXUP after 32nd iteration.
REQ-020 FIXUP: quotient negated if operand signs differ (signed ops); remainder takes dividend sign; -> DONE.
REQ-021 Divisor zero SHALL bypass DIV_ITER: DIV/DIVU result 0xFFFFFFFF, REM/REMU result = rs1_data.
REQ-022 Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF, DIV/REM) SHALL bypass DIV_ITER: DIV result 0x80000000, REM result 0.
REQ-023 DONE: done=1 one cycle, result valid, -> IDLE; start in DONE SHALL be ignored.
REQ-024 Latency start-to-done: MUL ops 4 cycles with a 2-cycle multiplier response (start@T, mul_enable@T+1, mul_resp@T+3, done@T+4); DIV ops 35 cycles; special cases 3 cycles.
REQ-025 result SHALL hold last value after done until the next completion; start while busy=1 SHALL be ignored.

Reset
REQ-026 rst=1 SHALL force IDLE, busy=0, done=0, mul_enable=0, result=0, mul_a=0, mul_b=0, counter=0 on the next edge.
REQ-027 rst mid-operation SHALL abandon the op with no done pulse; a mul_resp arriving after reset in IDLE SHALL be ignored.

Verification
REQ-028 MUL rs1=0xFFFFFFFF(-1), rs2=7 -> mul_a=1, mul_b=7, one mul_enable pulse, done@T+4, result=0xFFFFFFF9.
REQ-029 MULHU rs1=rs2=0xFFFFFFFF -> result=0xFFFFFFFE; MULH same operands -> result=0x00000000; MULHSU same -> result=0xFFFFFFFF.
REQ-030 DIV rs1=-7 (0xFFFFFFF9), rs2=2 -> done 35 cycles after start, result=0xFFFFFFFD; REM same operands -> result=0xFFFFFFFF.
REQ-031 DIVU rs2=0 rs1=0x1234 -> result 0xFFFFFFFF; REMU -> result 0x1234; DIV 0x80000000/0xFFFFFFFF -> result 0x80000000; all with done 3 cycles after start.
REQ-032 start re-asserted every cycle during a DIV -> single done, busy high throughout; rst at iteration 10 -> busy=0 next cycle, no done, next MUL completes correctly.
